// File: rtl/irq_pkg.sv
// irq_pkg
// Shared definitions for the interrupt responder: the responder's state
// enumeration and the address and event-counter widths.
// No ports; imported by irq_responder.
package irq_pkg;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_responder.sv
// irq_responder
// Takes a level interrupt from the interrupt controller at an interruptible
// boundary. It saves the return PC and redirects the pipeline to the handler
// vector. It tracks the handler until eret, then redirects back to the saved
// PC. Only one interrupt is handled at a time; there is no nesting.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   irq          interrupt request level (held until iack)
//   irq_addr     handler vector, valid while irq=1
//   iack         one-cycle acknowledge, asserted in the entry cycle
//   pc_current   PC at the interruptible boundary this cycle
//   stall        pipeline cannot take a redirect this cycle
//   eret         return-from-interrupt decoded this cycle
//   ie_we/ie_wd  software write of the global interrupt enable
//   redirect     force a PC load this cycle
//   redirect_pc  redirect target, 0 when not redirecting
//   flush        squash younger instructions; same as redirect
//   epc          saved return PC
//   ie           global interrupt enable
//   in_isr       handler is executing
//   irq_count    number of interrupts taken, wraps at 255
module irq_responder
    import irq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [ADDR_W-1:0] irq_addr,
    output logic              iack,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic              stall,
    input  logic              eret,
    input  logic              ie_we,
    input  logic              ie_wd,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [ADDR_W-1:0] epc,
    output logic              ie,
    output logic              in_isr,
    output logic [CNT_W-1:0]  irq_count
);

    irq_state_e        state_q, state_d;
    logic              ie_q, ie_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] vector_q, vector_d;
    logic [CNT_W-1:0]  irq_count_q, irq_count_d;

    // Next-state logic. ENTER and RETURN always last exactly one cycle.
    // The pipeline can only be redirected when stall is low, so the take and
    // return decisions wait on stall in IDLE and SERVICE.
    always_comb begin
        state_d     = state_q;
        ie_d        = ie_q;
        epc_d       = epc_q;
        vector_d    = vector_q;
        irq_count_d = irq_count_q;

        case (state_q)
            ST_IDLE: begin
                // The take decision uses ie_q, which is the value before any
                // software write made in the same cycle.
                if (irq && ie_q && !stall) begin
                    epc_d    = pc_current;
                    vector_d = irq_addr;
                    state_d  = ST_ENTER;
                end
                if (ie_we) begin
                    ie_d = ie_wd;
                end
            end
            ST_ENTER: begin
                ie_d        = 1'b0;
                irq_count_d = irq_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d     = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (eret && !stall) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                ie_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ie_q        <= 1'b0;
            epc_q       <= '0;
            vector_q    <= '0;
            irq_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ie_q        <= ie_d;
            epc_q       <= epc_d;
            vector_q    <= vector_d;
            irq_count_q <= irq_count_d;
        end
    end

    // All outputs come only from registered state, so nothing reaches them
    // combinationally from the inputs.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        iack        = 1'b0;
        in_isr      = 1'b0;
        case (state_q)
            ST_ENTER: begin
                redirect    = 1'b1;
                redirect_pc = vector_q;
                iack        = 1'b1;
            end
            ST_SERVICE: begin
                in_isr = 1'b1;
            end
            ST_RETURN: begin
                redirect    = 1'b1;
                redirect_pc = epc_q;
            end
            default: begin
            end
        endcase
    end

    assign flush     = redirect;
    assign epc       = epc_q;
    assign ie        = ie_q;
    assign irq_count = irq_count_q;

endmodule

// File: tb/tb_irq_responder.sv
// tb_irq_responder
// Drives directed scenarios and then a random run into irq_responder. Each
// cycle it compares every output with a behavioural reference model. The
// model describes the responder as "a pending redirect" plus "handler active"
// bookkeeping instead of as a state machine.
module tb_irq_responder;

    logic        clk;
    logic        rst;
    logic        irq;
    logic [31:0] irq_addr;
    logic        iack;
    logic [31:0] pc_current;
    logic        stall;
    logic        eret;
    logic        ie_we;
    logic        ie_wd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] epc;
    logic        ie;
    logic        in_isr;
    logic [7:0]  irq_count;

    int checks;
    int errors;

    // Reference model state.
    // pending_kind: 0 = no redirect this cycle, 1 = handler entry, 2 = return.
    int          pending_kind;
    bit          handler_active;
    bit          m_enable;
    logic [31:0] m_saved_pc;
    logic [31:0] m_vector;
    int          m_count;

    irq_responder dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .irq_addr    (irq_addr),
        .iack        (iack),
        .pc_current  (pc_current),
        .stall       (stall),
        .eret        (eret),
        .ie_we       (ie_we),
        .ie_wd       (ie_wd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .epc         (epc),
        .ie          (ie),
        .in_isr      (in_isr),
        .irq_count   (irq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value with its expected value, counts the check
    // and reports it if they differ.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        pending_kind   = 0;
        handler_active = 1'b0;
        m_enable       = 1'b0;
        m_saved_pc     = '0;
        m_vector       = '0;
        m_count        = 0;
    endtask

    // Outputs expected for the cycle the model is currently in.
    task automatic compareAll();
        logic        exp_redirect;
        logic [31:0] exp_target;
        exp_redirect = (pending_kind != 0);
        exp_target   = (pending_kind == 1) ? m_vector :
                       (pending_kind == 2) ? m_saved_pc : 32'h0;
        checkOutput("redirect",    {31'b0, redirect}, {31'b0, exp_redirect});
        checkOutput("flush",       {31'b0, flush},    {31'b0, exp_redirect});
        checkOutput("redirect_pc", redirect_pc,       exp_target);
        checkOutput("iack",        {31'b0, iack},     {31'b0, pending_kind == 1});
        checkOutput("in_isr",      {31'b0, in_isr},   {31'b0, handler_active && pending_kind == 0});
        checkOutput("ie",          {31'b0, ie},       {31'b0, m_enable});
        checkOutput("epc",         epc,               m_saved_pc);
        checkOutput("irq_count",   {24'b0, irq_count}, m_count[31:0]);
    endtask

    // Advances the model over one rising edge, using the inputs currently driven.
    task automatic modelStep();
        if (!rst) begin
            modelReset();
        end else if (pending_kind == 1) begin
            pending_kind   = 0;
            handler_active = 1'b1;
            m_enable       = 1'b0;
            m_count        = (m_count + 1) % 256;
        end else if (pending_kind == 2) begin
            pending_kind   = 0;
            handler_active = 1'b0;
            m_enable       = 1'b1;
        end else if (handler_active) begin
            if (eret && !stall) pending_kind = 2;
        end else begin
            if (irq && m_enable && !stall) begin
                m_saved_pc   = pc_current;
                m_vector     = irq_addr;
                pending_kind = 1;
            end
            if (ie_we) m_enable = ie_wd;
        end
    endtask

    // At the falling edge, checks the outputs for the current cycle. It then
    // drives the inputs for the next rising edge and steps the model over
    // that edge.
    task automatic applyStimulus(input logic r, input logic i, input logic [31:0] a,
                                 input logic [31:0] pc, input logic s, input logic e,
                                 input logic we, input logic wd);
        @(negedge clk);
        compareAll();
        rst        = r;
        irq        = i;
        irq_addr   = a;
        pc_current = pc;
        stall      = s;
        eret       = e;
        ie_we      = we;
        ie_wd      = wd;
        modelStep();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; irq = 1'b0; irq_addr = '0; pc_current = '0;
        stall = 1'b0; eret = 1'b0; ie_we = 1'b0; ie_wd = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);

        $display("[TB] basic take and return");
        resetCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("entry_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("entry_target", redirect_pc, 32'h40);
        checkOutput("entry_iack", {31'b0, iack}, 32'h1);
        checkOutput("entry_epc", epc, 32'h1C);
        idleCycle();
        afterEdge();
        checkOutput("service_count", {24'b0, irq_count}, 32'h1);
        checkOutput("service_in_isr", {31'b0, in_isr}, 32'h1);
        checkOutput("service_iack", {31'b0, iack}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        afterEdge();
        checkOutput("return_target", redirect_pc, 32'h1C);
        idleCycle();
        afterEdge();
        checkOutput("return_ie", {31'b0, ie}, 32'h1);
        checkOutput("return_redirect", {31'b0, redirect}, 32'h0);

        $display("[TB] masked irq then enable");
        resetCycle();
        repeat (10) applyStimulus(1'b1, 1'b1, 32'h100, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h50, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("late_take_target", redirect_pc, 32'h100);
        idleCycle();

        $display("[TB] stalled take");
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycle();
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h2C, 1'b0, 1'b0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("stall_epc", epc, 32'h2C);
        idleCycle();

        $display("[TB] eret with new irq");
        applyStimulus(1'b1, 1'b1, 32'h80, 32'h30, 1'b0, 1'b1, 1'b0, 1'b0);
        afterEdge();
        checkOutput("eret_wins_target", redirect_pc, 32'h2C);
        applyStimulus(1'b1, 1'b1, 32'h80, 32'h34, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h80, 32'h38, 1'b0, 1'b0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("pending_target", redirect_pc, 32'h80);
        idleCycle();

        $display("[TB] reset during service");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("rst_in_isr", {31'b0, in_isr}, 32'h0);
        checkOutput("rst_ie", {31'b0, ie}, 32'h0);
        checkOutput("rst_count", {24'b0, irq_count}, 32'h0);
        checkOutput("rst_redirect", {31'b0, redirect}, 32'h0);

        $display("[TB] random run");
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] addr;
            logic [31:0] pc;
            addr = $urandom;
            pc   = $urandom;
            applyStimulus(($urandom_range(0, 99) >= 2),
                          ($urandom_range(0, 99) < 55),
                          addr, pc,
                          ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 80));
        end
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
